// File: rtl/arm7_pkg.sv
// Shared definitions for the banked ARM7 register file: mode indices,
// 5-bit CPSR mode encodings, CPSR bit positions and bank-select helpers.
package arm7_pkg;

  localparam logic [2:0] MODE_USR = 3'd0;
  localparam logic [2:0] MODE_SYS = 3'd1;
  localparam logic [2:0] MODE_FIQ = 3'd2;
  localparam logic [2:0] MODE_IRQ = 3'd3;
  localparam logic [2:0] MODE_SVC = 3'd4;
  localparam logic [2:0] MODE_ABT = 3'd5;
  localparam logic [2:0] MODE_UND = 3'd6;

  localparam logic [4:0] ENC_USR = 5'b10000;
  localparam logic [4:0] ENC_SYS = 5'b11111;
  localparam logic [4:0] ENC_FIQ = 5'b10001;
  localparam logic [4:0] ENC_IRQ = 5'b10010;
  localparam logic [4:0] ENC_SVC = 5'b10011;
  localparam logic [4:0] ENC_ABT = 5'b10111;
  localparam logic [4:0] ENC_UND = 5'b11011;

  localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;
  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;

  function automatic logic [4:0] mode_encoding(input logic [2:0] idx);
    case (idx)
      MODE_SYS: return ENC_SYS;
      MODE_FIQ: return ENC_FIQ;
      MODE_IRQ: return ENC_IRQ;
      MODE_SVC: return ENC_SVC;
      MODE_ABT: return ENC_ABT;
      MODE_UND: return ENC_UND;
      default:  return ENC_USR;
    endcase
  endfunction

  // R13/R14 bank: USR and SYS share bank 0, privileged modes get 1..5.
  function automatic logic [2:0] r13_14_bank_of(input logic [2:0] idx);
    return (idx < MODE_FIQ) ? 3'd0 : idx - 3'd1;
  endfunction

endpackage

// File: rtl/arm7_mode_decode.sv
// Decodes a 5-bit CPSR mode field.
// Ports:
//   mode_bits   - CPSR[4:0] style encoding
//   mode_idx    - mode index (USR=0 .. UND=6), 0 when invalid
//   valid       - encoding is one of the seven architectural modes
//   has_spsr    - mode owns an SPSR (FIQ..UND)
//   fiq_bank    - R8-R12 come from the FIQ copy
//   r13_14_bank - bank select for R13/R14 (0..5)
module arm7_mode_decode
  import arm7_pkg::*;
(
  input  logic [4:0] mode_bits,
  output logic [2:0] mode_idx,
  output logic       valid,
  output logic       has_spsr,
  output logic       fiq_bank,
  output logic [2:0] r13_14_bank
);

  always_comb begin
    mode_idx = MODE_USR;
    valid    = 1'b1;
    case (mode_bits)
      ENC_USR: mode_idx = MODE_USR;
      ENC_SYS: mode_idx = MODE_SYS;
      ENC_FIQ: mode_idx = MODE_FIQ;
      ENC_IRQ: mode_idx = MODE_IRQ;
      ENC_SVC: mode_idx = MODE_SVC;
      ENC_ABT: mode_idx = MODE_ABT;
      ENC_UND: mode_idx = MODE_UND;
      default: valid    = 1'b0;
    endcase
  end

  assign has_spsr    = valid && (mode_idx >= MODE_FIQ);
  assign fiq_bank    = valid && (mode_idx == MODE_FIQ);
  assign r13_14_bank = r13_14_bank_of(mode_idx);

endmodule

// File: rtl/arm7_regfile.sv
// Banked ARM7 register file with CPSR/SPSR storage.
// Responds to single-cycle register, mode and CPSR read/write pulses from the
// ALU; reads are registered and hold until the next request. Exposes the PC
// to fetch, advances it on pc_advance and performs exception-entry banking.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   read_en/read_reg/read_value   - register read (R15 reads pc+PC_READ_OFFSET)
//   write_en/write_reg/write_value, write_restore_from_SPSR - register write
//   mode_read_en/mode_read_value  - current mode index read
//   cpsr_read_en/cpsr_read_value  - CPSR read
//   cpsr_write_en/cpsr_write_value- CPSR write
//   pc, pc_advance                - live R15 and +4 pulse
//   exc_en/exc_mode/exc_vector    - exception entry
module arm7_regfile
  import arm7_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR     = RESET_CPSR_DEFAULT,
  parameter logic [31:0] PC_READ_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  output logic [31:0] pc,
  input  logic        pc_advance,
  input  logic        exc_en,
  input  logic [2:0]  exc_mode,
  input  logic [31:0] exc_vector
);

  logic [31:0] cpsr;
  logic [31:0] gpr_lo [8];
  logic [31:0] usr_hi [5];
  logic [31:0] fiq_hi [5];
  logic [31:0] r13_b  [6];
  logic [31:0] r14_b  [6];
  logic [31:0] spsr   [2:6];

  logic [2:0] cur_idx, cur_bank;
  logic       cur_valid, cur_has_spsr, cur_fiq;

  arm7_mode_decode u_cur_dec (
    .mode_bits   (cpsr[4:0]),
    .mode_idx    (cur_idx),
    .valid       (cur_valid),
    .has_spsr    (cur_has_spsr),
    .fiq_bank    (cur_fiq),
    .r13_14_bank (cur_bank)
  );

  logic [2:0] wr_mode_idx;
  logic       wr_mode_valid;
  logic       wr_unused_spsr, wr_unused_fiq;
  logic [2:0] wr_unused_bank;

  arm7_mode_decode u_wr_dec (
    .mode_bits   (cpsr_write_value[4:0]),
    .mode_idx    (wr_mode_idx),
    .valid       (wr_mode_valid),
    .has_spsr    (wr_unused_spsr),
    .fiq_bank    (wr_unused_fiq),
    .r13_14_bank (wr_unused_bank)
  );

  logic        exc_ok, restore_ok, wr_pc;
  logic [31:0] reg_rd;

  assign exc_ok     = exc_en && (exc_mode >= MODE_FIQ) && (exc_mode <= MODE_UND);
  assign restore_ok = write_en && write_restore_from_SPSR && cur_valid && cur_has_spsr;
  assign wr_pc      = write_en && (write_reg == 4'd15);

  always_comb begin
    reg_rd = '0;
    if (read_reg == 4'd15)      reg_rd = pc + PC_READ_OFFSET;
    else if (read_reg == 4'd14) reg_rd = r14_b[cur_bank];
    else if (read_reg == 4'd13) reg_rd = r13_b[cur_bank];
    else if (read_reg[3])       reg_rd = cur_fiq ? fiq_hi[read_reg[2:0]] : usr_hi[read_reg[2:0]];
    else                        reg_rd = gpr_lo[read_reg[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) gpr_lo[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        usr_hi[i] <= '0;
        fiq_hi[i] <= '0;
      end
      for (int i = 0; i < 6; i++) begin
        r13_b[i] <= '0;
        r14_b[i] <= '0;
      end
      for (int i = 2; i <= 6; i++) spsr[i] <= '0;
      cpsr            <= RESET_CPSR;
      pc              <= '0;
      read_value      <= '0;
      mode_read_value <= '0;
      cpsr_read_value <= '0;
    end else begin
      // Reads capture pre-update state; no bypass from same-cycle writes.
      if (read_en)      read_value      <= reg_rd;
      if (mode_read_en) mode_read_value <= {29'd0, cur_idx};
      if (cpsr_read_en) cpsr_read_value <= cpsr;

      // Non-R15 writes land in the current (pre-restore/pre-exception) bank.
      if (write_en && !wr_pc) begin
        if (write_reg == 4'd14)      r14_b[cur_bank] <= write_value;
        else if (write_reg == 4'd13) r13_b[cur_bank] <= write_value;
        else if (write_reg[3]) begin
          if (cur_fiq) fiq_hi[write_reg[2:0]] <= write_value;
          else         usr_hi[write_reg[2:0]] <= write_value;
        end else       gpr_lo[write_reg[2:0]] <= write_value;
      end

      if (exc_ok) begin
        // Placed after the bank write so the link register wins if both hit.
        spsr[exc_mode]                 <= cpsr;
        r14_b[r13_14_bank_of(exc_mode)] <= pc;
        cpsr <= {cpsr[31:8], 1'b1, (exc_mode == MODE_FIQ) | cpsr[CPSR_F], 1'b0,
                 mode_encoding(exc_mode)};
        pc   <= {exc_vector[31:2], 2'b00};
      end else begin
        if (wr_pc)           pc <= {write_value[31:2], 2'b00};
        else if (pc_advance) pc <= pc + 32'd4;

        if (restore_ok)         cpsr <= spsr[cur_idx];
        else if (cpsr_write_en) cpsr <= {cpsr_write_value[31:5],
                                         wr_mode_valid ? mode_encoding(wr_mode_idx) : cpsr[4:0]};
      end
    end
  end

endmodule

// File: tb/tb_arm7_regfile.sv
module tb_arm7_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic [3:0]  read_reg = '0;
  logic [31:0] read_value;
  logic        write_en = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [31:0] write_value = '0;
  logic        write_restore_from_SPSR = 1'b0;
  logic        mode_read_en = 1'b0;
  logic [31:0] mode_read_value;
  logic        cpsr_read_en = 1'b0;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en = 1'b0;
  logic [31:0] cpsr_write_value = '0;
  logic [31:0] pc;
  logic        pc_advance = 1'b0;
  logic        exc_en = 1'b0;
  logic [2:0]  exc_mode = '0;
  logic [31:0] exc_vector = '0;
  logic        pc_chk = 1'b0;

  arm7_regfile dut (
    .clk                     (clk),
    .rst                     (rst),
    .read_en                 (read_en),
    .read_reg                (read_reg),
    .read_value              (read_value),
    .write_en                (write_en),
    .write_reg               (write_reg),
    .write_value             (write_value),
    .write_restore_from_SPSR (write_restore_from_SPSR),
    .mode_read_en            (mode_read_en),
    .mode_read_value         (mode_read_value),
    .cpsr_read_en            (cpsr_read_en),
    .cpsr_read_value         (cpsr_read_value),
    .cpsr_write_en           (cpsr_write_en),
    .cpsr_write_value        (cpsr_write_value),
    .pc                      (pc),
    .pc_advance              (pc_advance),
    .exc_en                  (exc_en),
    .exc_mode                (exc_mode),
    .exc_vector              (exc_vector)
  );

  always #5 clk = ~clk;

  logic [31:0] q_reg[$], q_mode[$], q_cpsr[$], q_pc[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output presented with no expected value queued at %0t", name, $time);
  endtask

  // Monitor: outputs hold between requests, so every cycle is compared against
  // the last expected value; a sampled request pops the next expectation.
  initial begin : monitor
    logic s_rst, s_rd, s_md, s_cp, s_pc;
    logic [31:0] h_reg, h_mode, h_cpsr;
    logic live;
    live = 1'b0;
    h_reg = '0; h_mode = '0; h_cpsr = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_rd = read_en; s_md = mode_read_en; s_cp = cpsr_read_en; s_pc = pc_chk;
      #1;
      if (s_rst) begin
        live = 1'b1;
        h_reg = '0; h_mode = '0; h_cpsr = '0;
      end else if (live) begin
        if (s_rd) begin
          if (q_reg.size() == 0) underflow("read_value");
          else h_reg = q_reg.pop_front();
        end
        if (s_md) begin
          if (q_mode.size() == 0) underflow("mode_read_value");
          else h_mode = q_mode.pop_front();
        end
        if (s_cp) begin
          if (q_cpsr.size() == 0) underflow("cpsr_read_value");
          else h_cpsr = q_cpsr.pop_front();
        end
        if (s_pc) begin
          if (q_pc.size() == 0) underflow("pc");
          else check("pc", pc, q_pc.pop_front());
        end
      end
      if (live) begin
        check("read_value", read_value, h_reg);
        check("mode_read_value", mode_read_value, h_mode);
        check("cpsr_read_value", cpsr_read_value, h_cpsr);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic go();
    @(negedge clk);
    read_en = 0; write_en = 0; write_restore_from_SPSR = 0; mode_read_en = 0;
    cpsr_read_en = 0; cpsr_write_en = 0; pc_advance = 0; exc_en = 0; pc_chk = 0;
  endtask

  task automatic rd(input logic [3:0] r, input logic [31:0] exp);
    read_en = 1; read_reg = r; q_reg.push_back(exp);
  endtask
  task automatic wr(input logic [3:0] r, input logic [31:0] v);
    write_en = 1; write_reg = r; write_value = v;
  endtask
  task automatic mode_rd(input logic [31:0] exp);
    mode_read_en = 1; q_mode.push_back(exp);
  endtask
  task automatic cpsr_rd(input logic [31:0] exp);
    cpsr_read_en = 1; q_cpsr.push_back(exp);
  endtask
  task automatic cpsr_wr(input logic [31:0] v);
    cpsr_write_en = 1; cpsr_write_value = v;
  endtask
  task automatic pc_exp(input logic [31:0] exp);
    pc_chk = 1; q_pc.push_back(exp);
  endtask
  task automatic exc(input logic [2:0] m, input logic [31:0] vec);
    exc_en = 1; exc_mode = m; exc_vector = vec;
  endtask

  initial begin : stimulus
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state
    cpsr_rd(32'hD3); mode_rd(32'd4); rd(4'd0, 32'd0); pc_exp(32'd0); go();

    // USR basic write/read, hold, R15 read offset
    cpsr_wr(32'h10); go();
    cpsr_rd(32'h10); mode_rd(32'd0); go();
    wr(4'd3, 32'h1234); go();
    rd(4'd3, 32'h1234); go();
    repeat (5) go();
    wr(4'd15, 32'h100); pc_exp(32'h100); go();
    rd(4'd15, 32'h108); go();

    // Banking of R8 and R13
    cpsr_wr(32'h11); go();
    wr(4'd8, 32'hAA); go();
    wr(4'd13, 32'hBB); go();
    cpsr_wr(32'h10); go();
    wr(4'd8, 32'h11); go();
    rd(4'd8, 32'h11); go();
    rd(4'd13, 32'h0); go();
    cpsr_wr(32'h11); go();
    rd(4'd8, 32'hAA); go();
    rd(4'd13, 32'hBB); go();

    // IRQ entry from USR, then restore
    cpsr_wr(32'hF000_0010); go();
    wr(4'd15, 32'h200); go();
    exc(3'd3, 32'h18); pc_exp(32'h18); go();
    cpsr_rd(32'hF000_0092); mode_rd(32'd3); go();
    rd(4'd14, 32'h200); go();
    wr(4'd15, 32'h204); write_restore_from_SPSR = 1; pc_exp(32'h204); go();
    cpsr_rd(32'hF000_0010); mode_rd(32'd0); go();
    rd(4'd14, 32'h0); go();

    // Same-cycle read/write: no bypass
    wr(4'd3, 32'h5555); rd(4'd3, 32'h1234); go();
    rd(4'd3, 32'h5555); go();

    // Restore in SYS is ignored; unaligned R15 write
    cpsr_wr(32'h1F); go();
    wr(4'd15, 32'h303); write_restore_from_SPSR = 1; pc_exp(32'h300); go();
    cpsr_rd(32'h1F); go();

    // pc_advance and collision with R15 write
    pc_advance = 1; pc_exp(32'h304); go();
    pc_advance = 1; wr(4'd15, 32'h400); pc_exp(32'h400); go();

    // Invalid mode encoding keeps CPSR[4:0], flags still written
    cpsr_wr(32'hA000_001A); go();
    cpsr_rd(32'hA000_001F); mode_rd(32'd1); go();

    // FIQ entry beats cpsr write and pc_advance; unaligned vector
    exc(3'd2, 32'h1F); cpsr_wr(32'h10); pc_advance = 1; pc_exp(32'h1C); go();
    cpsr_rd(32'hA000_00D1); mode_rd(32'd2); go();
    rd(4'd14, 32'h400); go();
    rd(4'd8, 32'hAA); go();
    rd(4'd13, 32'hBB); go();
    wr(4'd15, 32'h503); write_restore_from_SPSR = 1; pc_exp(32'h500); go();
    cpsr_rd(32'hA000_001F); go();

    // exc_mode outside 2..6 is a no-op
    exc(3'd7, 32'h40); pc_exp(32'h500); go();
    cpsr_rd(32'hA000_001F); go();

    // Non-R15 write lands in pre-exception bank
    wr(4'd13, 32'h77); exc(3'd4, 32'h8); pc_exp(32'h8); go();
    cpsr_rd(32'hA000_0093); mode_rd(32'd4); go();
    rd(4'd13, 32'h0); go();
    cpsr_wr(32'h1F); go();
    rd(4'd13, 32'h77); go();

    // Reset mid-operation
    rd(4'd3, 32'h5555); cpsr_rd(32'h1F); go();
    rst = 1; go();
    rst = 0;
    cpsr_rd(32'hD3); mode_rd(32'd4); rd(4'd3, 32'h0); pc_exp(32'h0); go();
    go();

    check("queues_drained", 32'(q_reg.size() + q_mode.size() + q_cpsr.size() + q_pc.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm7_regfile.md
Name: arm7_regfile

Overview:
- Banked ARM7 register file plus CPSR/SPSR storage.
- Acts as the responder for the ALU's register, mode and CPSR request ports.
- Also serves the fetch side: it exposes the PC, accepts PC-advance pulses, and performs exception-entry banking.
- Every request is a single-cycle pulse; reads answer one cycle later and hold their value.

Parameters:
- RESET_CPSR, 32'h000000D3, CPSR value after reset (SVC mode, I and F set).
- PC_READ_OFFSET, 8, value added to R15 when R15 is read through read_reg.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- read_en  in  1  register read request pulse.
- read_reg  in  4  register index to read.
- read_value  out  32  registered read data.
- write_en  in  1  register write pulse.
- write_reg  in  4  register index to write.
- write_value  in  32  write data.
- write_restore_from_SPSR  in  1  with write_en: copy SPSR[current mode] into CPSR.
- mode_read_en  in  1  mode read request pulse.
- mode_read_value  out  32  zero-extended 3-bit mode index.
- cpsr_read_en  in  1  CPSR read request pulse.
- cpsr_read_value  out  32  registered CPSR.
- cpsr_write_en  in  1  CPSR write pulse.
- cpsr_write_value  in  32  new CPSR.
- pc  out  32  current R15, continuous.
- pc_advance  in  1  pc += 4.
- exc_en  in  1  exception entry pulse.
- exc_mode  in  3  target mode index (2..6).
- exc_vector  in  32  new PC on exception entry.

Behaviour:
- Mode index: USR=0 (10000), SYS=1 (11111), FIQ=2 (10001), IRQ=3 (10010), SVC=4 (10011), ABT=5 (10111), UND=6 (11011). Derived combinationally from CPSR[4:0].
- Banks:
  - R0–R7 and R15 are shared.
  - R8–R12 have a USR copy and a FIQ copy.
  - R13–R14 have a USR/SYS copy plus one copy each for FIQ, IRQ, SVC, ABT, UND.
  - SPSR exists for indices 2..6 only.
- Reset: all GPRs and SPSRs 0; pc=0; CPSR=RESET_CPSR; read_value, mode_read_value and cpsr_read_value all 0.
- Read ports:
  - Each *_read_en sampled high updates its output at that edge; the output then holds until the next request.
  - read_en with read_reg=15 returns pc+PC_READ_OFFSET.
  - A read sampled in the same cycle as a write to the same target returns the pre-write value. There is no bypass.
- Register write: on write_en, the register in the current bank is updated.
  - Writing R15 sets pc=write_value[31:2],2'b00.
  - A write to R15 wins over a simultaneous pc_advance.
- Restore:
  - write_en && write_restore_from_SPSR with mode index ≥2: CPSR <= SPSR[current mode] at the same edge.
  - The register write uses the pre-restore bank.
  - With index 0/1 the flag is ignored.
  - Restore overrides a simultaneous cpsr_write_en.
- CPSR write:
  - cpsr_write_en writes all bits.
  - If cpsr_write_value[4:0] is not a valid encoding, CPSR[4:0] retains its old value; the other bits are still written.
- Exception entry: exc_en with exc_mode in 2..6 performs, at one edge:
  - SPSR[exc_mode] <= CPSR.
  - R14[exc_mode] <= pc.
  - CPSR[4:0] <= encoding(exc_mode); CPSR[7] <= 1; CPSR[6] <= 1 when FIQ; CPSR[5] <= 0.
  - pc <= exc_vector aligned.
- Exception priority:
  - exc_en beats pc_advance, R15 writes, cpsr_write_en and restore; those are dropped that cycle.
  - Non-R15 register writes in the same cycle still occur in the pre-exception bank.
  - exc_mode outside 2..6 makes exc_en a no-op.
- pc_advance: pc <= pc+4, wrapping modulo 2^32.
- rst mid-operation: all state returns to reset values and pending outputs clear; no partial updates.

Decomposition:
- Package arm7_pkg:
  - mode index constants and 5-bit encodings.
  - RESET_CPSR default.
  - CPSR bit positions (N=31, Z=30, C=29, V=28, I=7, F=6, T=5).
- Sub-module arm7_mode_decode: 5-bit mode → index, valid, has_spsr, fiq_bank, r13_14 bank select. It is used both on the live CPSR and on cpsr_write_value.

Test Plan:
- Reset → cpsr_read_value=32'hD3 after a cpsr_read_en pulse; pc=0; mode_read_value=4 after a mode_read_en pulse.
- In USR, write R3=0x1234 → pulse read_en with read_reg=3 → read_value=0x1234 one cycle later and held 5 cycles. Read R15 with pc=0x100 → 0x108.
- Banking:
  - In FIQ write R8=0xAA and R13=0xBB; switch to USR and write R8=0x11.
  - USR reads R8=0x11 and R13=0.
  - Back in FIQ: R8=0xAA, R13=0xBB.
- Exception entry: IRQ entry from USR with CPSR=0xF0000010, pc=0x200, exc_vector=0x18 → SPSR_irq=0xF0000010, R14_irq=0x200, CPSR=0xF0000092, pc=0x18.
- Restore: in IRQ, write R15=0x204 with restore → pc=0x204, CPSR=0xF0000010. The same in SYS leaves CPSR unchanged.
- Collisions:
  - pc_advance together with a write R15=0x400 → pc=0x400.
  - cpsr_write_value=0x0000001A → CPSR[4:0] unchanged.
  - exc_en together with cpsr_write_en → exception values win.
